// File: rtl/alu_mdu_unit_if.sv
// EX-stage bus between the controller and the ALU/multiply-divide unit.
// The controller drives the request side; the unit returns result, flags and HI/LO.
interface alu_mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ALUOp, Funct, in_a, in_b,
    input  result, zero, busy, done, hi, lo
  );

  modport slave (
    input  start, ALUOp, Funct, in_a, in_b,
    output result, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_mdu_unit.sv
// ALU control decode plus single-cycle ALU with registered result, and an
// iterative shift-add multiplier / restoring divider writing HI/LO.
module alu_mdu_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_mdu_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLL,
    OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MUL, OP_DIV
  } op_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return {(2*WIDTH){1'b0}} - v;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d, dz_q, dz_d;

  op_t                op_s;
  logic               sign_s, lt_s, a_neg_s, b_neg_s;
  logic [SHW-1:0]     shamt_s;
  logic [WIDTH-1:0]   alu_s, a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operation decode, operand magnitudes and the single-cycle ALU result
  always_comb begin
    sign_s = (bus.ALUOp[2:0] == 3'b010) ? ~bus.Funct[0] : ~bus.ALUOp[3];
    op_s   = OP_ADD;
    case (bus.ALUOp[2:0])
      3'b000: op_s = OP_ADD;
      3'b001: op_s = OP_SUB;
      3'b100: op_s = OP_AND;
      3'b101: op_s = OP_SLT;
      3'b010: begin
        case (bus.Funct)
          6'h00:        op_s = OP_SLL;
          6'h02:        op_s = OP_SRL;
          6'h03:        op_s = OP_SRA;
          6'h20, 6'h21: op_s = OP_ADD;
          6'h22, 6'h23: op_s = OP_SUB;
          6'h24:        op_s = OP_AND;
          6'h25:        op_s = OP_OR;
          6'h26:        op_s = OP_XOR;
          6'h27:        op_s = OP_NOR;
          6'h2A, 6'h2B: op_s = OP_SLT;
          6'h10:        op_s = OP_MFHI;
          6'h12:        op_s = OP_MFLO;
          6'h11:        op_s = OP_MTHI;
          6'h13:        op_s = OP_MTLO;
          6'h18, 6'h19: op_s = OP_MUL;
          6'h1A, 6'h1B: op_s = OP_DIV;
          default:      op_s = OP_ADD;
        endcase
      end
      default: op_s = OP_ADD;
    endcase

    shamt_s = bus.in_a[SHW-1:0];
    lt_s    = sign_s ? ($signed(bus.in_a) < $signed(bus.in_b)) : (bus.in_a < bus.in_b);
    a_neg_s = sign_s & bus.in_a[WIDTH-1];
    b_neg_s = sign_s & bus.in_b[WIDTH-1];
    a_mag_s = a_neg_s ? neg_w(bus.in_a) : bus.in_a;
    b_mag_s = b_neg_s ? neg_w(bus.in_b) : bus.in_b;

    case (op_s)
      OP_ADD:  alu_s = bus.in_a + bus.in_b;
      OP_SUB:  alu_s = bus.in_a - bus.in_b;
      OP_AND:  alu_s = bus.in_a & bus.in_b;
      OP_OR:   alu_s = bus.in_a | bus.in_b;
      OP_XOR:  alu_s = bus.in_a ^ bus.in_b;
      OP_NOR:  alu_s = ~(bus.in_a | bus.in_b);
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLL:  alu_s = bus.in_b << shamt_s;
      OP_SRL:  alu_s = bus.in_b >> shamt_s;
      OP_SRA:  alu_s = $signed(bus.in_b) >>> shamt_s;
      OP_MFHI: alu_s = hi_q;
      OP_MFLO: alu_s = lo_q;
      default: alu_s = result_q;
    endcase
  end

  // One shift-add and one restoring-division step on the shared accumulator
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, opnd_q};
    prod_s     = neg_q ? neg_2w(acc_q) : acc_q;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && (op_s == OP_MUL)) begin
          state_d = MUL;
        end else if (bus.start && (op_s == OP_DIV)) begin
          state_d = DIV;
        end else begin
          state_d = IDLE;
        end
      end
      MUL:     state_d = (cnt_q == CNT_ONE) ? FIX : MUL;
      DIV:     state_d = (cnt_q == CNT_ONE) ? FIX : DIV;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start && ((op_s == OP_MUL) || (op_s == OP_DIV))) begin
          acc_d    = {{WIDTH{1'b0}}, a_mag_s};
          opnd_d   = b_mag_s;
          cnt_d    = CNT_INIT;
          is_div_d = (op_s == OP_DIV);
          neg_d    = a_neg_s ^ b_neg_s;
          sa_d     = a_neg_s;
          dz_d     = (b_mag_s == {WIDTH{1'b0}});
        end else if (bus.start) begin
          done_d   = 1'b1;
          result_d = alu_s;
          if (op_s == OP_MTHI) begin
            hi_d = bus.in_a;
          end else if (op_s == OP_MTLO) begin
            lo_d = bus.in_a;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      MUL: begin
        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
      end
      DIV: begin
        if (div_sh_s >= {1'b0, opnd_q}) begin
          acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
      end
      FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          // Divide by zero leaves the dividend magnitude in the remainder, so hi ends up as in_a
          hi_d = sa_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
          lo_d = dz_q ? {WIDTH{1'b1}} :
                 (neg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = (result_q == {WIDTH{1'b0}});
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
endmodule
